// File: rtl/audio_demux.sv
// audio_demux: host-written stereo frame FIFO, drained one frame per I2S word-clock period.
// Bus-mapped control/status; a prefill threshold gates playback and underruns fall back to prefill.
module audio_demux #(
    parameter int FIFO_WIDTH    = 6,
    parameter int AUD_BIT_DEPTH = 24
) (
    input  logic                     clk,
    input  logic                     reset_reg_N,
    input  logic [2:0]               address,
    input  logic                     read,
    input  logic                     write,
    input  logic [31:0]              datain,
    output logic [31:0]              dataout,
    input  logic                     lrck,
    output logic [AUD_BIT_DEPTH-1:0] lsound_out,
    output logic [AUD_BIT_DEPTH-1:0] rsound_out,
    output logic                     sample_valid,
    output logic [FIFO_WIDTH:0]      fifo_level,
    output logic                     underrun
);
    localparam int unsigned DEPTH = 2 ** FIFO_WIDTH;
    localparam logic [FIFO_WIDTH:0]   LVL_FULL = {1'b1, {FIFO_WIDTH{1'b0}}};
    localparam logic [FIFO_WIDTH:0]   LVL_HALF = {2'b01, {(FIFO_WIDTH-1){1'b0}}};
    localparam logic [FIFO_WIDTH:0]   LVL_ONE  = {{FIFO_WIDTH{1'b0}}, 1'b1};
    localparam logic [FIFO_WIDTH-1:0] PTR_ONE  = {{(FIFO_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {ST_IDLE, ST_PREFILL, ST_RUN} state_t;

    state_t                         state_q, state_d;
    logic                           lrck_s1_q, lrck_s2_q, lrck_s3_q;
    logic [2*AUD_BIT_DEPTH-1:0]     mem_q [DEPTH];
    logic [FIFO_WIDTH-1:0]          wr_ptr_q, rd_ptr_q;
    logic [FIFO_WIDTH:0]            level_q, level_d, thr_q, thr_new;
    logic [AUD_BIT_DEPTH-1:0]       stage_l_q, lsound_q, lsound_d, rsound_q, rsound_d;
    logic                           enable_q, ovf_q, urun_q, valid_q;
    logic [15:0]                    ucnt_q;
    logic [31:0]                    dout_q, rd_val;

    logic tick, full, empty, wr_l, push_req, wr_ctrl, wr_thr, flush, clr, push, pop, urun_evt;
    logic [AUD_BIT_DEPTH-1:0]       din_smp;
    logic [2*AUD_BIT_DEPTH-1:0]     head;
    logic                           unused_bits;

    assign tick     = lrck_s2_q & ~lrck_s3_q;
    assign full     = (level_q == LVL_FULL);
    assign empty    = (level_q == '0);
    assign wr_l     = write && (address == 3'd0);
    assign push_req = write && (address == 3'd1);
    assign wr_ctrl  = write && (address == 3'd2);
    assign wr_thr   = write && (address == 3'd3);
    assign flush    = wr_ctrl && datain[1];
    assign clr      = wr_ctrl && datain[2];
    assign push     = push_req && !full && !flush;
    assign din_smp  = datain[31:32-AUD_BIT_DEPTH];
    assign head     = mem_q[rd_ptr_q];
    assign unused_bits = ^datain;

    always_comb begin
        if (datain[FIFO_WIDTH:0] == '0)
            thr_new = LVL_ONE;
        else if (datain[FIFO_WIDTH:0] > LVL_FULL)
            thr_new = LVL_FULL;
        else
            thr_new = datain[FIFO_WIDTH:0];
    end

    always_comb begin
        rd_val = '0;
        case (address)
            3'd2:    rd_val = {27'b0, ovf_q, urun_q, full, empty, enable_q};
            3'd3:    rd_val = {{(31-FIFO_WIDTH){1'b0}}, level_q};
            3'd4:    rd_val = {16'b0, ucnt_q};
            default: rd_val = '0;
        endcase
    end

    // Disable overrides everything; a tick on an empty FIFO in RUN is an underrun, not a pop.
    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        urun_evt = 1'b0;
        if (!enable_q) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    state_d = ST_PREFILL;
                ST_PREFILL: if (!flush && level_q >= thr_q) state_d = ST_RUN;
                ST_RUN: begin
                    if (flush) begin
                        state_d = ST_PREFILL;
                    end else if (tick) begin
                        if (empty) begin
                            urun_evt = 1'b1;
                            state_d  = ST_PREFILL;
                        end else begin
                            pop = 1'b1;
                        end
                    end
                end
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        lsound_d = lsound_q;
        rsound_d = rsound_q;
        if (pop) begin
            lsound_d = head[2*AUD_BIT_DEPTH-1:AUD_BIT_DEPTH];
            rsound_d = head[AUD_BIT_DEPTH-1:0];
        end else if (state_d != ST_RUN) begin
            lsound_d = '0;
            rsound_d = '0;
        end
    end

    always_comb begin
        level_d = level_q;
        if (flush)
            level_d = '0;
        else if (push && !pop)
            level_d = level_q + LVL_ONE;
        else if (pop && !push)
            level_d = level_q - LVL_ONE;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {stage_l_q, din_smp};
    end

    always_ff @(posedge clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            state_q   <= ST_IDLE;
            lrck_s1_q <= 1'b0;
            lrck_s2_q <= 1'b0;
            lrck_s3_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            thr_q     <= LVL_HALF;
            stage_l_q <= '0;
            enable_q  <= 1'b0;
            ovf_q     <= 1'b0;
            urun_q    <= 1'b0;
            ucnt_q    <= '0;
            lsound_q  <= '0;
            rsound_q  <= '0;
            valid_q   <= 1'b0;
            dout_q    <= '0;
        end else begin
            state_q   <= state_d;
            lrck_s1_q <= lrck;
            lrck_s2_q <= lrck_s1_q;
            lrck_s3_q <= lrck_s2_q;
            level_q   <= level_d;
            lsound_q  <= lsound_d;
            rsound_q  <= rsound_d;
            valid_q   <= pop;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (wr_l)    stage_l_q <= din_smp;
            if (wr_ctrl) enable_q  <= datain[0];
            if (wr_thr)  thr_q     <= thr_new;
            if (read)    dout_q    <= rd_val;
            if (clr) begin
                ovf_q  <= 1'b0;
                urun_q <= 1'b0;
                ucnt_q <= '0;
            end else begin
                if (push_req && full) ovf_q <= 1'b1;
                if (urun_evt) begin
                    urun_q <= 1'b1;
                    if (ucnt_q != 16'hFFFF) ucnt_q <= ucnt_q + 16'd1;
                end
            end
        end
    end

    assign dataout      = dout_q;
    assign lsound_out   = lsound_q;
    assign rsound_out   = rsound_q;
    assign sample_valid = valid_q;
    assign fifo_level   = level_q;
    assign underrun     = urun_q;

endmodule

// File: tb/tb_audio_demux.sv
// tb_audio_demux: directed scenarios plus randomized bus/lrck traffic, checked every cycle
// against a queue-based reference model of the playback FIFO.
module tb_audio_demux;
    localparam int W     = 2;
    localparam int DEPTH = 4;
    localparam int A     = 24;
    localparam int M_IDLE = 0, M_PRE = 1, M_RUN = 2;

    logic          clk = 1'b0;
    logic          reset_reg_N = 1'b0;
    logic [2:0]    address = '0;
    logic          read = 1'b0, write = 1'b0, lrck = 1'b0;
    logic [31:0]   datain = '0;
    logic [31:0]   dataout;
    logic [A-1:0]  lsound_out, rsound_out;
    logic          sample_valid, underrun;
    logic [W:0]    fifo_level;

    int n_vec = 0;
    int n_err = 0;

    audio_demux #(.FIFO_WIDTH(W), .AUD_BIT_DEPTH(A)) dut (
        .clk(clk), .reset_reg_N(reset_reg_N), .address(address), .read(read),
        .write(write), .datain(datain), .dataout(dataout), .lrck(lrck),
        .lsound_out(lsound_out), .rsound_out(rsound_out), .sample_valid(sample_valid),
        .fifo_level(fifo_level), .underrun(underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: frames in a queue, decisions taken from the state before each edge.
    logic [47:0] mq[$];
    int          m_mode, m_thr, m_ucnt, lvl, nmode;
    bit          m_en, m_ovf, m_urf, m_sv, h1, h2, h3;
    bit          full, empty, tick, ctrl, flush, clr, pop, urun;
    logic [A-1:0] m_stage, m_l, m_r;
    logic [31:0] m_dout;

    function automatic logic [31:0] reg_read(input logic [2:0] a, input int lv);
        case (a)
            3'd2:    return {27'b0, m_ovf, m_urf, lv == DEPTH, lv == 0, m_en};
            3'd3:    return 32'(lv);
            3'd4:    return 32'(m_ucnt);
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            mq.delete();
            m_mode = M_IDLE; m_thr = DEPTH / 2; m_ucnt = 0;
            m_en = 0; m_ovf = 0; m_urf = 0; m_sv = 0;
            h1 = 0; h2 = 0; h3 = 0;
            m_stage = '0; m_l = '0; m_r = '0; m_dout = '0;
        end else begin
            lvl   = mq.size();
            full  = (lvl == DEPTH);
            empty = (lvl == 0);
            tick  = h2 && !h3;              // lrck seen high two edges ago, low three edges ago
            ctrl  = write && address == 3'd2;
            flush = ctrl && datain[1];
            clr   = ctrl && datain[2];
            pop   = 0;
            urun  = 0;
            nmode = m_mode;
            if (read) m_dout = reg_read(address, lvl);
            if (!m_en)                  nmode = M_IDLE;
            else if (m_mode == M_IDLE)  nmode = M_PRE;
            else if (m_mode == M_PRE) begin
                if (!flush && lvl >= m_thr) nmode = M_RUN;
            end
            else if (flush)             nmode = M_PRE;
            else if (tick) begin
                if (empty) begin urun = 1; nmode = M_PRE; end
                else pop = 1;
            end
            m_sv = pop;
            if (pop) begin
                m_l = mq[0][47:24];
                m_r = mq[0][23:0];
            end else if (nmode != M_RUN) begin
                m_l = '0;
                m_r = '0;
            end
            if (flush) mq.delete();
            else begin
                if (pop) void'(mq.pop_front());
                if (write && address == 3'd1 && !full) mq.push_back({m_stage, datain[31:8]});
            end
            if (write && address == 3'd1 && full) m_ovf = 1;
            if (urun) begin
                m_urf = 1;
                if (m_ucnt < 65535) m_ucnt++;
            end
            if (clr) begin m_ovf = 0; m_urf = 0; m_ucnt = 0; end
            if (write && address == 3'd0) m_stage = datain[31:8];
            if (ctrl) m_en = datain[0];
            if (write && address == 3'd3) begin
                m_thr = int'(datain[2:0]);
                if (m_thr == 0) m_thr = 1;
                if (m_thr > DEPTH) m_thr = DEPTH;
            end
            m_mode = nmode;
            h3 = h2; h2 = h1; h1 = lrck;
        end
    end

    always @(negedge clk) begin
        if (reset_reg_N) begin
            chk("lsound", 32'(lsound_out), 32'(m_l));
            chk("rsound", 32'(rsound_out), 32'(m_r));
            chk("sample_valid", 32'(sample_valid), 32'(m_sv));
            chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
            chk("underrun", 32'(underrun), 32'(m_urf));
            chk("dataout", dataout, m_dout);
        end
    end

    task automatic drive(input logic w, input logic r, input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        write = w; read = r; address = a; datain = d;
    endtask
    task automatic nop();                                     drive(0, 0, 3'd0, 32'h0); endtask
    task automatic wr(input logic [2:0] a, input logic [31:0] d); drive(1, 0, a, d);      endtask
    task automatic rd(input logic [2:0] a);                   drive(0, 1, a, 32'h0);    endtask
    task automatic push(input logic [23:0] l, input logic [23:0] r);
        wr(3'd0, {l, 8'h00});
        wr(3'd1, {r, 8'h00});
    endtask
    task automatic lr_low();
        nop(); lrck = 1'b0; repeat (4) nop();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int r, ppct;
        repeat (2) @(negedge clk);
        reset_reg_N = 1'b1;
        chk("rst_lsound", 32'(lsound_out), 32'h0);
        chk("rst_level", 32'(fifo_level), 32'h0);

        // Basic playback of two frames
        wr(3'd3, 32'd2); wr(3'd2, 32'd1);
        push(24'h111111, 24'h222222);
        push(24'h333333, 24'h444444);
        nop(); chk("lvl2", 32'(fifo_level), 32'd2);
        nop(); nop();
        lrck = 1'b1; nop(); nop();
        chk("sv_early", 32'(sample_valid), 32'd0);
        nop();
        chk("sv_lat3", 32'(sample_valid), 32'd1);
        chk("f1_l", 32'(lsound_out), 32'h111111);
        chk("f1_r", 32'(rsound_out), 32'h222222);
        chk("lvl1", 32'(fifo_level), 32'd1);
        lr_low();
        lrck = 1'b1; repeat (3) nop();
        chk("f2_l", 32'(lsound_out), 32'h333333);
        chk("f2_r", 32'(rsound_out), 32'h444444);
        chk("lvl0", 32'(fifo_level), 32'd0);
        lr_low();

        // Underrun and clear
        lrck = 1'b1; repeat (3) nop();
        chk("ur_l", 32'(lsound_out), 32'h0);
        chk("ur_flag", 32'(underrun), 32'd1);
        lr_low();
        rd(3'd2); nop(); chk("ur_status", dataout, 32'h0B);
        rd(3'd4); nop(); chk("ur_count", dataout, 32'd1);
        wr(3'd2, 32'h5);
        rd(3'd2); nop(); chk("clr_status", dataout, 32'h03);
        rd(3'd4); nop(); chk("clr_count", dataout, 32'd0);
        push(24'h0A0A0A, 24'h0B0B0B); nop();
        lrck = 1'b1; repeat (3) nop();
        chk("prefill_nopop", 32'(fifo_level), 32'd1);
        lr_low();
        wr(3'd2, 32'h2);

        // Overflow while disabled, then drain
        for (int i = 0; i < 5; i++) push(24'hA00000 + 24'(i), 24'hB00000 + 24'(i));
        nop(); chk("ovf_level", 32'(fifo_level), 32'd4);
        rd(3'd2); nop(); chk("ovf_status", dataout, 32'h14);
        wr(3'd2, 32'h1); repeat (3) nop();
        for (int i = 0; i < 4; i++) begin
            lrck = 1'b1; repeat (3) nop();
            chk("drain_l", 32'(lsound_out), 32'hA00000 + 32'(i));
            chk("drain_r", 32'(rsound_out), 32'hB00000 + 32'(i));
            lr_low();
        end
        lrck = 1'b1; repeat (3) nop();
        chk("fifth_absent", 32'(sample_valid), 32'd0);
        lr_low();
        wr(3'd2, 32'h5);

        // Flush from RUN at full level
        wr(3'd2, 32'h0);
        for (int i = 0; i < 4; i++) push(24'hC00000 + 24'(i), 24'hD00000);
        wr(3'd2, 32'h1); repeat (3) nop();
        wr(3'd2, 32'h3); nop();
        chk("flush_level", 32'(fifo_level), 32'd0);
        lrck = 1'b1; repeat (3) nop();
        chk("flush_nopop", 32'(sample_valid), 32'd0);
        chk("flush_nour", 32'(underrun), 32'd0);
        lr_low();

        // Push coinciding with a pop at level 3, then at full
        for (int i = 0; i < 3; i++) push(24'hE00000 + 24'(i), 24'hF00000 + 24'(i));
        nop(); nop();
        wr(3'd0, 32'hE00003_00); lrck = 1'b1; nop();
        wr(3'd1, 32'hF00003_00); nop();
        chk("pp3_level", 32'(fifo_level), 32'd3);
        chk("pp3_l", 32'(lsound_out), 32'hE00000);
        lr_low();
        push(24'hE00004, 24'hF00004); nop();
        chk("pp4_full", 32'(fifo_level), 32'd4);
        wr(3'd0, 32'hE00005_00); lrck = 1'b1; nop();
        wr(3'd1, 32'hF00005_00); nop();
        chk("pp4_level", 32'(fifo_level), 32'd3);
        chk("pp4_l", 32'(lsound_out), 32'hE00001);
        lr_low();
        rd(3'd2); nop(); chk("pp4_status", dataout, 32'h11);

        // Asynchronous reset between clock edges
        chk("pre_rst_l", 32'(lsound_out), 32'hE00001);
        @(posedge clk); #3; reset_reg_N = 1'b0; #1;
        chk("arst_l", 32'(lsound_out), 32'h0);
        chk("arst_r", 32'(rsound_out), 32'h0);
        chk("arst_level", 32'(fifo_level), 32'h0);
        @(negedge clk); reset_reg_N = 1'b1;
        rd(3'd2); nop(); chk("post_rst_status", dataout, 32'h02);

        // Randomized traffic: push-heavy first half, pop-heavy second half
        for (int i = 0; i < 3000; i++) begin
            ppct = (i < 1500) ? 30 : 6;
            if ($urandom_range(0, 5) == 0) lrck = ~lrck;
            r = $urandom_range(0, 99);
            if (r < ppct)            wr(3'd0 + 3'($urandom_range(0, 1)), $urandom);
            else if (r < ppct + 6) begin
                case ($urandom_range(0, 9))
                    6:       wr(3'd2, 32'h0);
                    7:       wr(3'd2, 32'h3);
                    8:       wr(3'd2, 32'h5);
                    9:       wr(3'd2, 32'h7);
                    default: wr(3'd2, 32'h1);
                endcase
            end
            else if (r < ppct + 10)  wr(3'd3, 32'($urandom_range(0, 7)));
            else if (r < ppct + 25)  rd(3'($urandom_range(0, 7)));
            else                     nop();
        end
        nop(); nop();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/audio_demux.md
Name: audio_demux

Overview:
Playback-direction counterpart of the CPU audio read port. The host CPU writes stereo sample frames over the register bus into a frame FIFO. The block drains one frame per I2S frame (rising edge of lrck) and presents it as parallel left/right samples to the codec/I2S transmitter side. It handles prefill, underrun and overflow, and exposes status and fill level on the same bus.

Parameters:
FIFO_WIDTH, 6, log2 of FIFO depth in stereo frames (depth = 2^FIFO_WIDTH)
AUD_BIT_DEPTH, 24, sample width; samples occupy datain/dataout[31:32-AUD_BIT_DEPTH]

Ports:
clk  in  1  system clock, all logic on rising edge
reset_reg_N  in  1  asynchronous active-low reset
address  in  3  register select
read  in  1  bus read strobe, one cycle
write  in  1  bus write strobe, one cycle
datain  in  32  bus write data
dataout  out  32  bus read data, registered
lrck  in  1  I2S word clock, asynchronous; synchronised internally with a 2-flop synchroniser
lsound_out  out  AUD_BIT_DEPTH  left sample to I2S side
rsound_out  out  AUD_BIT_DEPTH  right sample to I2S side
sample_valid  out  1  one-cycle pulse when outputs load a popped frame
fifo_level  out  FIFO_WIDTH+1  current fill level in frames
underrun  out  1  sticky underrun flag

Behaviour:
- Reset: all outputs 0; FIFO empty; state IDLE; enable=0; threshold=2^(FIFO_WIDTH-1); sticky flags, underrun count and L staging register = 0.
- Register writes:
  - addr 0: stage left sample.
  - addr 1: right sample; pushes {staged L, R} as one frame if not full. If full: frame dropped, overflow sticky set.
  - addr 2: bit0 enable; bit1 flush (self-clearing pulse); bit2 clear sticky flags and underrun count.
  - addr 3: prefill threshold = datain[FIFO_WIDTH:0]; 0 is treated as 1; values above depth clamp to depth.
- Register reads: dataout is updated on the edge sampling read and valid the next cycle; unlisted addresses return 0.
  - addr 2: {27'b0, overflow, underrun, full, empty, enable}.
  - addr 3: zero-extended fifo_level.
  - addr 4: {16'b0, underrun_count}.
- Frame tick: single-cycle pulse on the first clk after rising edge of synced lrck. Latency from lrck rise is 3 clk.
- State machine:
  - IDLE: outputs held at 0; no pops. Goes to PREFILL when enable=1.
  - PREFILL: no pops; outputs 0. Goes to RUN when fifo_level >= threshold.
  - RUN: on each tick, pop the head frame and register it to lsound_out/rsound_out. sample_valid pulses in the same cycle the outputs change. If tick occurs while empty: outputs forced 0, underrun sticky set, underrun_count increments (saturating at 0xFFFF), go to PREFILL.
  - Any state: enable=0 returns to IDLE next cycle. FIFO contents are retained.
- Simultaneous events:
  - push+pop in the same cycle: both succeed; level unchanged.
  - push while full with a same-cycle pop: full is evaluated before the pop, so the push is dropped and overflow is flagged.
  - flush has priority over push and pop in that cycle. It empties the FIFO, and RUN moves to PREFILL.
- Pointers wrap modulo 2^FIFO_WIDTH. Level is FIFO_WIDTH+1 bits: full = level==2^FIFO_WIDTH, empty = level==0.
- Reset asserted mid-operation clears everything immediately (async); outputs go to 0 with no glitch dependency on clk.

Test Plan:
- Reset, write threshold 2, enable; push frames (L=0x111111,R=0x222222),(0x333333,0x444444); toggle lrck -> PREFILL→RUN; first tick outputs 0x111111/0x222222 with sample_valid pulse, second tick outputs 0x333333/0x444444; level 2→1→0.
- Continue ticks with FIFO empty -> outputs 0, status bit3=1, addr4 reads 1, state returns to PREFILL; clear via addr2 bit2 -> status bit3=0, count 0.
- FIFO_WIDTH=2: push 5 frames without enable -> level 4, full=1, overflow=1, fifth frame absent on drain.
- Level 4, flush write coincident with push -> level 0 after; next tick yields no pop while in PREFILL.
- Push on a tick cycle at level 3 (depth 4) -> level stays 3; at level 4 with a same-cycle pop -> level 3, overflow set.
- Assert reset_reg_N low mid-RUN between clk edges -> lsound_out/rsound_out/fifo_level 0 immediately; after release, addr2 reads 0x02 (empty).
